// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the 8-source round-robin mux scheduler.
package mux_sched_pkg;
  localparam int N_SRC = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  function automatic logic [N_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_SRC'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_pick8.sv
// Combinational circular priority finder: first set bit of (req & mask) scanning from ptr upward with wrap.
module rr_pick8
  import mux_sched_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_SRC-1:0] mask,
  output logic             any,
  output logic [SEL_W-1:0] idx
);
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] rot;
  logic [SEL_W-1:0] off;

  assign cand = req & mask;

  // rot[0] is the candidate at ptr, rot[1] the one after it, and so on (3-bit index wraps)
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_rot
    assign rot[gi] = cand[ptr + SEL_W'(gi)];
  end

  always_comb begin
    off = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign any = |rot;
  assign idx = ptr + off;
endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler owning the select of a shared 8:1 bit mux, with bounded bursts,
// optional turnaround gap, freeze input and a registered copy of the selected data bit.
module mux8_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter bit GAP_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  input  logic             hold,
  input  logic [N_SRC-1:0] a,
  output logic [N_SRC-1:0] gnt,
  output logic [SEL_W-1:0] s,
  output logic             vld,
  output logic             y
);
  localparam int CNT_W = (MAX_BURST == 0) ? 3 :
                         (($clog2(MAX_BURST + 1) < 1) ? 1 : $clog2(MAX_BURST + 1));
  localparam logic [CNT_W-1:0] CNT_MAX = (MAX_BURST == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_BURST);

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [SEL_W-1:0] s_reg, s_next;
  logic             vld_reg, vld_next;
  logic [N_SRC-1:0] gnt_reg, gnt_next;
  logic             y_reg, y_next;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] pick_ptr;
  logic [N_SRC-1:0] pick_mask;
  logic             burst_done;
  logic             release_now;

  // While granting, the picker already looks past the current owner so a back-to-back
  // hand-off uses the advanced pointer in the release cycle itself.
  assign pick_ptr  = (state_reg == GRANT) ? s_reg + SEL_W'(1) : ptr_reg;
  assign pick_mask = (state_reg == GRANT) ? ~onehot(s_reg) : {N_SRC{1'b1}};

  rr_pick8 u_pick (
    .req  (req),
    .ptr  (pick_ptr),
    .mask (pick_mask),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign burst_done  = (MAX_BURST != 0) && (cnt_reg == CNT_MAX) && !hold;
  assign release_now = !req[s_reg] || burst_done;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    s_next     = s_reg;
    vld_next   = 1'b0;
    case (state_reg)
      // The gap cycle itself shows no grant; arbitration runs during it so only one idle cycle appears.
      IDLE, GAP: begin
        state_next = IDLE;
        if (!hold && pick_any) begin
          state_next = GRANT;
          s_next     = pick_idx;
          vld_next   = 1'b1;
          cnt_next   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_next   = s_reg + SEL_W'(1);
          state_next = GAP_EN ? GAP : IDLE;
          if (!GAP_EN && !hold && pick_any) begin
            state_next = GRANT;
            s_next     = pick_idx;
            vld_next   = 1'b1;
            cnt_next   = CNT_W'(1);
          end
        end else begin
          vld_next = 1'b1;
          if (!hold && cnt_reg != CNT_MAX) cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    gnt_next = vld_next ? onehot(s_next) : '0;
    y_next   = vld_next & a[s_next];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      s_reg     <= '0;
      vld_reg   <= 1'b0;
      gnt_reg   <= '0;
      y_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      s_reg     <= s_next;
      vld_reg   <= vld_next;
      gnt_reg   <= gnt_next;
      y_reg     <= y_next;
    end
  end

  assign gnt = gnt_reg;
  assign s   = s_reg;
  assign vld = vld_reg;
  assign y   = y_reg;
endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Scoreboard bench: burst/gap instance (MAX_BURST=4, GAP_EN=1) and back-to-back instance (MAX_BURST=2, GAP_EN=0).
module tb_mux8_rr_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_a = '0, req_b = '0, a = 8'hA5;
  logic       hold = 1'b0;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] s_a, s_b;
  logic       vld_a, vld_b, y_a, y_b;

  int n_cmp = 0;
  int n_err = 0;

  int m_state[2], m_ptr[2], m_cnt[2], m_s[2], m_vld[2];
  logic [12:0] q_a[$], q_b[$];

  always #5 clk = ~clk;

  mux8_rr_scheduler #(.MAX_BURST(4), .GAP_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req_a), .hold(hold), .a(a),
    .gnt(gnt_a), .s(s_a), .vld(vld_a), .y(y_a)
  );

  mux8_rr_scheduler #(.MAX_BURST(2), .GAP_EN(1'b0)) dut_b2b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .hold(hold), .a(a),
    .gnt(gnt_b), .s(s_b), .vld(vld_b), .y(y_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int scan(input logic [7:0] r, input int ptr, input int excl);
    for (int i = 0; i < 8; i++) begin
      int j;
      j = (ptr + i) % 8;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0; m_s[k] = 0; m_vld[k] = 0;
    end
  endtask

  // state codes: 0 idle, 1 granting, 2 turnaround gap
  task automatic model_step(input int k, input logic [7:0] r, input logic h,
                            input logic [7:0] d, output logic [12:0] e);
    int mb, w;
    bit gap;
    logic [7:0] g;
    logic yy;
    mb  = (k == 0) ? 4 : 2;
    gap = (k == 0);
    w   = -1;
    if (m_state[k] == 1) begin
      if (!r[m_s[k]] || (m_cnt[k] == mb && !h)) begin
        m_ptr[k]   = (m_s[k] + 1) % 8;
        m_vld[k]   = 0;
        m_state[k] = gap ? 2 : 0;
        if (!gap && !h) w = scan(r, m_ptr[k], m_s[k]);
      end else if (!h && m_cnt[k] < mb) begin
        m_cnt[k]++;
      end
    end else begin
      m_state[k] = 0;
      m_vld[k]   = 0;
      if (!h) w = scan(r, m_ptr[k], -1);
    end
    if (w >= 0) begin
      m_s[k] = w; m_vld[k] = 1; m_cnt[k] = 1; m_state[k] = 1;
    end
    g  = (m_vld[k] != 0) ? (8'd1 << m_s[k]) : 8'd0;
    yy = (m_vld[k] != 0) ? d[m_s[k]] : 1'b0;
    e  = {g, 3'(m_s[k]), (m_vld[k] != 0), yy};
  endtask

  task automatic step();
    logic [12:0] ea, eb;
    model_step(0, req_a, hold, a, ea);
    model_step(1, req_b, hold, a, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
    @(posedge clk);
    #1;
    check("sb_a", {gnt_a, s_a, vld_a, y_a}, q_a.pop_front());
    check("sb_b", {gnt_b, s_b, vld_b, y_b}, q_b.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    req_a = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt_a, 0);
    check("rst_s", s_a, 0);
    check("rst_vld", vld_a, 0);
    check("rst_y", y_a, 0);
    rst_n = 1'b1;
    step();
    check("first_gnt", gnt_a, 8'h01);
    check("first_s", s_a, 0);

    req_a = 8'h00;
    repeat (3) step();

    // early release of source 2, one gap, then source 5
    req_a = 8'h24;
    step(); check("early_g1", gnt_a, 8'h04);
    step(); check("early_g2", gnt_a, 8'h04);
    req_a = 8'h20;
    step(); check("early_gap", vld_a, 0);
    step(); check("early_g5", gnt_a, 8'h20);
    check("early_s5", s_a, 5);
    check("data_y5", y_a, 1);

    // mid-burst asynchronous reset
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", gnt_a, 0);
    check("mid_rst_vld", vld_a, 0);
    model_reset();
    @(posedge clk);
    #1;
    check("mid_rst_s", s_a, 0);
    rst_n = 1'b1;

    // full rotation on the gap instance, back-to-back pair on the other
    req_a = 8'hFF;
    req_b = 8'h81;
    for (int t = 0; t < 45; t++) begin
      a = 8'($urandom);
      step();
      check("rot_vld", vld_a, ((t % 5) < 4) ? 1 : 0);
      if ((t % 5) < 4) check("rot_s", s_a, (t / 5) % 8);
      check("b2b_s", s_b, ((t / 2) % 2 != 0) ? 7 : 0);
      check("b2b_vld", vld_b, 1);
    end

    req_a = 8'h00;
    req_b = 8'h00;
    a = 8'hA5;
    repeat (3) step();
    check("idle_y", y_a, 0);

    req_a = 8'h02;
    step();
    check("data_s1", s_a, 1);
    check("data_y1", y_a, 0);
    req_a = 8'h00;
    repeat (2) step();

    // hold at full burst, then the request drops while frozen
    req_a = 8'h08;
    repeat (4) step();
    check("hold_cnt4", gnt_a, 8'h08);
    hold = 1'b1;
    repeat (3) step();
    check("hold_keep", gnt_a, 8'h08);
    req_a = 8'h00;
    step();
    check("hold_drop", gnt_a, 0);
    hold = 1'b0;
    repeat (2) step();

    // hold at full burst, released on the cycle after hold drops
    req_a = 8'h08;
    repeat (4) step();
    hold = 1'b1;
    repeat (2) step();
    check("hold2_keep", gnt_a, 8'h08);
    hold = 1'b0;
    step();
    check("hold2_rel", vld_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
